// File: rtl/kg_regfile_pkg.sv
`default_nettype none
// ============================================================================
// kg_regfile_pkg : register map, response codes and byte-strobe merge helper
//                  shared by axil_kg_ctrl_regs.
// Revision       : 1.0
// ============================================================================
package kg_regfile_pkg;

  // Word indices, decoded from addr[7:2]
  localparam logic [5:0] KG_REG_ADDRESS       = 6'h00;
  localparam logic [5:0] KG_REG_ADDRESS_VALID = 6'h01;
  localparam logic [5:0] KG_REG_DATA          = 6'h02;
  localparam logic [5:0] KG_REG_DATA_VALID    = 6'h03;
  localparam logic [5:0] KG_REG_ID            = 6'h04;
  localparam logic [5:0] KG_REG_SCRATCH       = 6'h05;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  strb
  );
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axil_kg_ctrl_regs.sv
`default_nettype none
// ============================================================================
// axil_kg_ctrl_regs : AXI4-Lite register file driving the Kugelblitz per-port
//                     byte-override controls. Optional macro
//                     KG_REGFILE_SLVERR_EN enables SLVERR on unmapped/RO writes.
// Revision          : 1.0
// ============================================================================
module axil_kg_ctrl_regs
  import kg_regfile_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int          STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [31:0] ID_VALUE   = 32'h4B47_0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [DATA_WIDTH-1:0] kg_address,
  output logic [DATA_WIDTH-1:0] kg_address_valid,
  output logic [DATA_WIDTH-1:0] kg_data,
  output logic [DATA_WIDTH-1:0] kg_data_valid
);

  generate
    if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("axil_kg_ctrl_regs: DATA_WIDTH must be 32");
    end
    if (ADDR_WIDTH < 8) begin : g_bad_addr_width
      $error("axil_kg_ctrl_regs: ADDR_WIDTH must be >= 8");
    end
    if (STRB_WIDTH != DATA_WIDTH / 8) begin : g_bad_strb_width
      $error("axil_kg_ctrl_regs: STRB_WIDTH must equal DATA_WIDTH/8");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_address;
  logic [DATA_WIDTH-1:0] r_address_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_data_valid;
  logic [DATA_WIDTH-1:0] r_scratch;

  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic [5:0]            w_wr_idx;
  logic [5:0]            w_rd_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_rd_map;
  logic [1:0]            w_bresp_next;
  logic [1:0]            w_rresp_next;
  logic                  w_unused;

  // Ready is combinational so a write/read can complete every second cycle.
  assign w_wr_fire = s_axil_awvalid & s_axil_wvalid & ~r_bvalid;
  assign w_rd_fire = s_axil_arvalid & ~r_rvalid;
  assign w_wr_idx  = s_axil_awaddr[7:2];
  assign w_rd_idx  = s_axil_araddr[7:2];

  always_comb begin
    w_rd_word = '0;
    w_rd_map  = 1'b1;
    case (w_rd_idx)
      KG_REG_ADDRESS:       w_rd_word = r_address;
      KG_REG_ADDRESS_VALID: w_rd_word = r_address_valid;
      KG_REG_DATA:          w_rd_word = r_data;
      KG_REG_DATA_VALID:    w_rd_word = r_data_valid;
      KG_REG_ID:            w_rd_word = ID_VALUE;
      KG_REG_SCRATCH:       w_rd_word = r_scratch;
      default:              w_rd_map  = 1'b0;
    endcase
  end

`ifdef KG_REGFILE_SLVERR_EN
  logic w_wr_ok;
  assign w_wr_ok      = (w_wr_idx <= KG_REG_SCRATCH) && (w_wr_idx != KG_REG_ID);
  assign w_bresp_next = w_wr_ok  ? RESP_OKAY : RESP_SLVERR;
  assign w_rresp_next = w_rd_map ? RESP_OKAY : RESP_SLVERR;
  assign w_unused     = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};
`else
  assign w_bresp_next = RESP_OKAY;
  assign w_rresp_next = RESP_OKAY;
  assign w_unused     = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr, w_rd_map};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_address       <= '0;
      r_address_valid <= '0;
      r_data          <= '0;
      r_data_valid    <= '0;
      r_scratch       <= '0;
    end else if (w_wr_fire) begin
      case (w_wr_idx)
        KG_REG_ADDRESS:       r_address       <= strb_merge(r_address,       s_axil_wdata, s_axil_wstrb);
        KG_REG_ADDRESS_VALID: r_address_valid <= strb_merge(r_address_valid, s_axil_wdata, s_axil_wstrb);
        KG_REG_DATA:          r_data          <= strb_merge(r_data,          s_axil_wdata, s_axil_wstrb);
        KG_REG_DATA_VALID:    r_data_valid    <= strb_merge(r_data_valid,    s_axil_wdata, s_axil_wstrb);
        KG_REG_SCRATCH:       r_scratch       <= strb_merge(r_scratch,       s_axil_wdata, s_axil_wstrb);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_wr_fire) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_bresp_next;
    end else if (s_axil_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read data is sampled from the pre-write register state, so a colliding
  // same-cycle write is not visible to the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (w_rd_fire) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rresp_next;
      r_rdata  <= w_rd_word;
    end else if (s_axil_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign s_axil_awready   = w_wr_fire;
  assign s_axil_wready    = w_wr_fire;
  assign s_axil_bvalid    = r_bvalid;
  assign s_axil_bresp     = r_bresp;
  assign s_axil_arready   = w_rd_fire;
  assign s_axil_rvalid    = r_rvalid;
  assign s_axil_rresp     = r_rresp;
  assign s_axil_rdata     = r_rdata;
  assign kg_address       = r_address;
  assign kg_address_valid = r_address_valid;
  assign kg_data          = r_data;
  assign kg_data_valid    = r_data_valid;

endmodule
`default_nettype wire

// File: tb/tb_axil_kg_ctrl_regs.sv
`default_nettype none
// ============================================================================
// tb_axil_kg_ctrl_regs : directed self-checking bench for axil_kg_ctrl_regs.
// Revision             : 1.0
// ============================================================================
module tb_axil_kg_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_axil_awaddr = '0;
  logic [2:0]  s_axil_awprot = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b0;
  logic [31:0] s_axil_araddr = '0;
  logic [2:0]  s_axil_arprot = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;
  logic [31:0] kg_address;
  logic [31:0] kg_address_valid;
  logic [31:0] kg_data;
  logic [31:0] kg_data_valid;

  int n_checks = 0;
  int n_pass   = 0;

  axil_kg_ctrl_regs dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_axil_awaddr    (s_axil_awaddr),
    .s_axil_awprot    (s_axil_awprot),
    .s_axil_awvalid   (s_axil_awvalid),
    .s_axil_awready   (s_axil_awready),
    .s_axil_wdata     (s_axil_wdata),
    .s_axil_wstrb     (s_axil_wstrb),
    .s_axil_wvalid    (s_axil_wvalid),
    .s_axil_wready    (s_axil_wready),
    .s_axil_bresp     (s_axil_bresp),
    .s_axil_bvalid    (s_axil_bvalid),
    .s_axil_bready    (s_axil_bready),
    .s_axil_araddr    (s_axil_araddr),
    .s_axil_arprot    (s_axil_arprot),
    .s_axil_arvalid   (s_axil_arvalid),
    .s_axil_arready   (s_axil_arready),
    .s_axil_rdata     (s_axil_rdata),
    .s_axil_rresp     (s_axil_rresp),
    .s_axil_rvalid    (s_axil_rvalid),
    .s_axil_rready    (s_axil_rready),
    .kg_address       (kg_address),
    .kg_address_valid (kg_address_valid),
    .kg_data          (kg_data),
    .kg_data_valid    (kg_data_valid)
  );

  always #5 clk = ~clk;

`ifdef KG_REGFILE_SLVERR_EN
  localparam logic [1:0] EXP_ERR = 2'b10;
`else
  localparam logic [1:0] EXP_ERR = 2'b00;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit ok = 0;
    s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_bready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_axil_awready && s_axil_wready) begin ok = 1; break; end
    end
    chk("aw_w_accept", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (s_axil_bvalid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("b_arrive", {31'b0, ok}, 32'd1);
    resp = s_axil_bresp;
    @(posedge clk); #1;
    s_axil_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ok = 0;
    s_axil_araddr = a; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_axil_arready) begin ok = 1; break; end
    end
    chk("ar_accept", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
    s_axil_arvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (s_axil_rvalid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("r_arrive", {31'b0, ok}, 32'd1);
    d = s_axil_rdata;
    resp = s_axil_rresp;
    @(posedge clk); #1;
    s_axil_rready = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  br, rr;
  bit          stall_ok;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bvalid", {31'b0, s_axil_bvalid}, 32'd0);
    chk("rst_rvalid", {31'b0, s_axil_rvalid}, 32'd0);
    chk("rst_kg_address", kg_address, 32'd0);
    chk("rst_kg_data", kg_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset readback
    axi_read(32'h00, rd, rr); chk("rst_rd_00", rd, 32'd0);
    axi_read(32'h04, rd, rr); chk("rst_rd_04", rd, 32'd0);
    axi_read(32'h08, rd, rr); chk("rst_rd_08", rd, 32'd0);
    axi_read(32'h0C, rd, rr); chk("rst_rd_0c", rd, 32'd0);
    axi_read(32'h10, rd, rr); chk("rst_rd_id", rd, 32'h4B47_0001);
    chk("rst_rd_id_resp", {30'b0, rr}, 32'd0);

    // Simple full-word write
    axi_write(32'h00, 32'h0000_002A, 4'hF, br);
    chk("wr00_bresp", {30'b0, br}, 32'd0);
    chk("wr00_kg_address", kg_address, 32'h2A);
    axi_read(32'h00, rd, rr); chk("wr00_readback", rd, 32'h2A);

    // Byte-strobe merge
    axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, br);
    axi_write(32'h08, 32'h0000_0055, 4'h1, br);
    chk("strb_kg_data", kg_data, 32'hFFFF_FF55);

    // B backpressure: second write must wait for bready
    s_axil_awaddr = 32'h04; s_axil_wdata = 32'h1; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_bready = 1'b0;
    @(negedge clk);
    chk("hold_first_accept", {31'b0, s_axil_awready & s_axil_wready}, 32'd1);
    @(posedge clk); #1;
    s_axil_awaddr = 32'h0C; s_axil_wdata = 32'h1;
    stall_ok = 1;
    repeat (5) begin
      @(negedge clk);
      if (!s_axil_bvalid || s_axil_awready || s_axil_wready) stall_ok = 0;
    end
    chk("hold_stall", {31'b0, stall_ok}, 32'd1);
    chk("hold_kg_address_valid", kg_address_valid, 32'd1);
    chk("hold_second_blocked", kg_data_valid, 32'd0);
    s_axil_bready = 1'b1;
    @(posedge clk); #1;
    s_axil_bready = 1'b0;
    chk("hold_b_drop", {31'b0, s_axil_bvalid}, 32'd0);
    @(negedge clk);
    chk("hold_second_accept", {31'b0, s_axil_awready & s_axil_wready}, 32'd1);
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    chk("hold_second_b", {31'b0, s_axil_bvalid}, 32'd1);
    s_axil_bready = 1'b1;
    @(posedge clk); #1;
    s_axil_bready = 1'b0;
    chk("hold_kg_data_valid", kg_data_valid, 32'd1);

    // Same-cycle write and read of SCRATCH: read sees the old value
    fork
      begin axi_write(32'h14, 32'h0000_1234, 4'hF, br); end
      begin axi_read(32'h14, rd, rr); end
    join
    chk("collide_old", rd, 32'd0);
    axi_read(32'h14, rd, rr); chk("collide_new", rd, 32'h1234);

    // Unmapped offsets
    axi_write(32'h40, 32'hDEAD_BEEF, 4'hF, br);
    chk("unmap_bresp", {30'b0, br}, {30'b0, EXP_ERR});
    axi_read(32'h40, rd, rr);
    chk("unmap_rdata", rd, 32'd0);
    chk("unmap_rresp", {30'b0, rr}, {30'b0, EXP_ERR});

    // ID is read-only
    axi_write(32'h10, 32'h0, 4'hF, br);
    chk("id_wr_bresp", {30'b0, br}, {30'b0, EXP_ERR});
    axi_read(32'h10, rd, rr); chk("id_unchanged", rd, 32'h4B47_0001);

    // 256-byte aliasing
    axi_write(32'h100, 32'h77, 4'hF, br);
    chk("alias_kg_address", kg_address, 32'h77);
    axi_read(32'h00, rd, rr); chk("alias_rd_00", rd, 32'h77);
    axi_read(32'h108, rd, rr); chk("alias_rd_108", rd, 32'hFFFF_FF55);

    // Asynchronous reset with a response outstanding
    s_axil_awaddr = 32'h08; s_axil_wdata = 32'h1; s_axil_wstrb = 4'h1;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_bready = 1'b0;
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    chk("mid_kg_data", kg_data, 32'hFFFF_FF01);
    chk("mid_bvalid", {31'b0, s_axil_bvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bvalid", {31'b0, s_axil_bvalid}, 32'd0);
    chk("mid_rst_kg_address", kg_address, 32'd0);
    chk("mid_rst_kg_data", kg_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
